// File: rtl/fib_sequencer.sv
// Fibonacci / Pell recurrence sequencer: DEPTH-term file filled one term per TICK_DIV clocks.
// Optional macro FIB_SATURATE_EN: overflowing terms clamp to all-ones instead of wrapping.
//
// state | meaning
// IDLE  | seeds loaded or reset; waiting for Start
// RUN   | generating terms 2..DEPTH-1, one per tick
// DONE  | all terms generated; file held
module fib_sequencer #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 30000000
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     SeedA,
  input  logic                     SeedB,
  input  logic [WIDTH-1:0]         SeedValue,
  input  logic                     Start,
  input  logic                     Mode,
  input  logic [$clog2(DEPTH)-1:0] RdAddr,
  output logic [WIDTH-1:0]         RdData,
  output logic [WIDTH-1:0]         Current,
  output logic [$clog2(DEPTH):0]   Index,
  output logic                     Busy,
  output logic                     Done,
  output logic                     Overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = AW + 1;
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] terms [DEPTH];
  logic [CW-1:0]    tick;
  logic             mode_q;
  logic [AW-1:0]    idx_m1;
  logic [AW-1:0]    idx_m2;
  logic [WIDTH-1:0] prev1;
  logic [WIDTH-1:0] prev2;
  logic [WIDTH+1:0] sum;
  logic             sum_ovf;
  logic [WIDTH-1:0] next_term;
  logic             seed;
  logic             step;

  assign seed   = SeedA | SeedB;
  assign step   = (state == RUN) && (tick == CW'(TICK_DIV - 1));
  assign idx_m1 = AW'(Index - IW'(1));
  assign idx_m2 = AW'(Index - IW'(2));
  assign prev1  = terms[idx_m1];
  assign prev2  = terms[idx_m2];

  // Two guard bits cover the Pell worst case 3*(2^WIDTH-1).
  always_comb begin
    if (mode_q) sum = ({2'b00, prev1} << 1) + {2'b00, prev2};
    else        sum = {2'b00, prev1} + {2'b00, prev2};
  end

  assign sum_ovf = |sum[WIDTH+1:WIDTH];

`ifdef FIB_SATURATE_EN
  assign next_term = sum_ovf ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
  assign next_term = sum[WIDTH-1:0];
`endif

  always_comb begin
    RdData = '0;
    if ({1'b0, RdAddr} < IW'(DEPTH)) RdData = terms[RdAddr];
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      for (int i = 0; i < DEPTH; i++) terms[i] <= '0;
      Current  <= '0;
      Index    <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Overflow <= 1'b0;
      tick     <= '0;
      mode_q   <= 1'b0;
    end else if (seed) begin
      // A seed overrides everything, including a Start in the same cycle.
      if (SeedA) terms[0] <= SeedValue;
      if (SeedB) terms[1] <= SeedValue;
      Current  <= SeedValue;
      state    <= IDLE;
      Index    <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Overflow <= 1'b0;
      tick     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            mode_q   <= Mode;
            Index    <= IW'(2);
            tick     <= '0;
            Overflow <= 1'b0;
            Done     <= 1'b0;
            Busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (step) begin
            tick                <= '0;
            terms[Index[AW-1:0]] <= next_term;
            Current             <= next_term;
            Index               <= Index + IW'(1);
            if (sum_ovf) Overflow <= 1'b1;
            if (Index == IW'(DEPTH - 1)) begin
              state <= DONE;
              Busy  <= 1'b0;
              Done  <= 1'b1;
            end
          end else begin
            tick <= tick + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_sequencer.sv
// Scoreboard bench for fib_sequencer: a reference model queues every expected term write,
// and an independent monitor pops and checks each write as the DUT makes it.
module tb_fib_sequencer;
  localparam int W  = 16;
  localparam int D  = 16;
  localparam int T  = 4;
  localparam int AW = 4;
  localparam int IW = 5;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          SeedA = 1'b0;
  logic          SeedB = 1'b0;
  logic [W-1:0]  SeedValue = '0;
  logic          Start = 1'b0;
  logic          Mode = 1'b0;
  logic [AW-1:0] RdAddr = '0;
  logic [W-1:0]  RdData;
  logic [W-1:0]  Current;
  logic [IW-1:0] Index;
  logic          Busy;
  logic          Done;
  logic          Overflow;

  fib_sequencer #(.WIDTH(W), .DEPTH(D), .TICK_DIV(T)) dut (
    .Clock(Clock), .Reset(Reset), .SeedA(SeedA), .SeedB(SeedB), .SeedValue(SeedValue),
    .Start(Start), .Mode(Mode), .RdAddr(RdAddr), .RdData(RdData), .Current(Current),
    .Index(Index), .Busy(Busy), .Done(Done), .Overflow(Overflow)
  );

  always #5 Clock = ~Clock;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    int           k;
    logic [W-1:0] val;
    logic         ovf;
    logic         done;
    longint       at;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  logic [W-1:0] mem [D];
  logic [W-1:0] cur_m;
  logic [IW-1:0] prev_idx = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: a generated write shows up as Index stepping by one from 2 or above.
  always @(negedge Clock) begin
    if (Reset && prev_idx >= 2 && Index == prev_idx + 1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=index %0d required=no write", Index);
      end else begin
        mon_e = sb.pop_front();
        chk("write_index", Index - 1, mon_e.k);
        chk($sformatf("write_value_t%0d", mon_e.k), Current, mon_e.val);
        chk($sformatf("write_overflow_t%0d", mon_e.k), Overflow, mon_e.ovf);
        chk($sformatf("write_done_t%0d", mon_e.k), Done, mon_e.done);
        chk($sformatf("write_busy_t%0d", mon_e.k), Busy, !mon_e.done);
        chk($sformatf("write_time_t%0d", mon_e.k), cyc, mon_e.at);
        mem[mon_e.k] = mon_e.val;
        cur_m = mon_e.val;
      end
    end
    prev_idx = Index;
  end

  // Reference model: the whole run computed by plain arithmetic from the stored seeds.
  task automatic push_run(input logic m, input longint start_at);
    logic [W-1:0] g [D];
    logic         ovf;
    longint       s;
    ovf  = 1'b0;
    g[0] = mem[0];
    g[1] = mem[1];
    for (int k = 2; k < D; k++) begin
      s = (m ? 2 : 1) * longint'(g[k-1]) + longint'(g[k-2]);
      if (s >= (longint'(1) << W)) begin
        ovf = 1'b1;
`ifdef FIB_SATURATE_EN
        g[k] = '1;
`else
        g[k] = W'(s);
`endif
      end else begin
        g[k] = W'(s);
      end
      sb.push_back('{k, g[k], ovf, (k == D - 1), start_at + longint'((k - 1) * T)});
    end
  endtask

  task automatic check_terms(input string name);
    for (int i = 0; i < D; i++) begin
      RdAddr = AW'(i);
      #1;
      chk($sformatf("%s_rd_term%0d", name, i), RdData, mem[i]);
    end
    chk({name, "_current"}, Current, cur_m);
  endtask

  task automatic do_seed(input logic a, input logic b, input logic [W-1:0] v, input logic st);
    @(posedge Clock); #2;
    SeedA = a; SeedB = b; SeedValue = v; Start = st;
    @(posedge Clock); #2;
    SeedA = 0; SeedB = 0; Start = 0; SeedValue = W'($urandom);
    sb.delete();
    if (a) mem[0] = v;
    if (b) mem[1] = v;
    cur_m = v;
    chk("seed_current", Current, v);
    chk("seed_index", Index, 0);
    chk("seed_busy", Busy, 0);
    chk("seed_done", Done, 0);
    chk("seed_overflow", Overflow, 0);
    RdAddr = b ? AW'(1) : AW'(0);
    #1;
    chk("seed_rd", RdData, v);
  endtask

  task automatic do_start(input logic m);
    @(posedge Clock); #2;
    Start = 1; Mode = m;
    push_run(m, cyc + 1);
    @(posedge Clock); #2;
    Start = 0; Mode = 1'($urandom_range(0, 1));
    chk("start_busy", Busy, 1);
    chk("start_index", Index, 2);
    chk("start_done", Done, 0);
    chk("start_overflow", Overflow, 0);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!Done && n < 300) begin
      @(posedge Clock); #2;
      n++;
    end
    #5;
    chk({name, "_done_reached"}, Done, 1);
    chk({name, "_queue_empty"}, sb.size(), 0);
    chk({name, "_index"}, Index, D);
    chk({name, "_busy"}, Busy, 0);
    check_terms(name);
  endtask

  task automatic wait_index(input int target);
    int n = 0;
    while (Index != IW'(target) && n < 300) begin
      @(posedge Clock); #2;
      n++;
    end
    chk("wait_index_reached", Index, target);
  endtask

  task automatic do_reset();
    @(posedge Clock); #2;
    Reset = 0;
    @(posedge Clock); #2;
    Reset = 1;
    sb.delete();
    for (int i = 0; i < D; i++) mem[i] = '0;
    cur_m = '0;
    chk("reset_current", Current, 0);
    chk("reset_index", Index, 0);
    chk("reset_busy", Busy, 0);
    chk("reset_done", Done, 0);
    chk("reset_overflow", Overflow, 0);
    check_terms("reset");
    repeat (2 * T) @(posedge Clock);
    #2;
    chk("reset_idle_index", Index, 0);
    chk("reset_idle_busy", Busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < D; i++) mem[i] = '0;
    cur_m = '0;
    do_reset();

    // Fibonacci from 0,1
    do_seed(1, 0, 16'd0, 0);
    do_seed(0, 1, 16'd1, 0);
    do_start(0);
    wait_done("fib");
    RdAddr = 4'd15; #1;
    chk("fib_term15", RdData, 610);
    chk("fib_overflow", Overflow, 0);

    // Pell from 0,1, with a stray Start mid-run that must be ignored
    do_start(1);
    wait_index(8);
    @(posedge Clock); #2; Start = 1; Mode = 0;
    @(posedge Clock); #2; Start = 0;
    wait_done("pell");
    RdAddr = 4'd2;  #1; chk("pell_term2", RdData, 2);
    RdAddr = 4'd3;  #1; chk("pell_term3", RdData, 5);
    RdAddr = 4'd4;  #1; chk("pell_term4", RdData, 12);
    RdAddr = 4'd5;  #1; chk("pell_term5", RdData, 29);
    RdAddr = 4'd10; #1; chk("pell_term10", RdData, 2378);

    // Seed mid-run: terms already generated are kept
    do_start(0);
    wait_index(6);
    do_seed(0, 1, 16'd7, 0);
    check_terms("midseed");

    // Both seeds together, then Start in the same cycle as a seed
    do_seed(1, 1, 16'd3, 0);
    do_seed(1, 1, 16'd3, 1);
    chk("seed_beats_start_busy", Busy, 0);
    do_start(0);
    wait_done("dual");
    RdAddr = 4'd2; #1; chk("dual_term2", RdData, 6);
    RdAddr = 4'd3; #1; chk("dual_term3", RdData, 9);

    // Restart straight from DONE with the other mode
    do_start(1);
    wait_done("redone");

    // Forced overflow on the first generated term
    do_seed(1, 1, 16'h8000, 0);
    do_start(0);
    wait_done("ovf");
    chk("ovf_sticky", Overflow, 1);

    // Randomized seeds and modes, half of them large enough to overflow
    for (int r = 0; r < 8; r++) begin
      if (r % 2 == 1) begin
        a = W'($urandom_range(16'h4000, 16'hFFFF));
        b = W'($urandom_range(16'h4000, 16'hFFFF));
      end else begin
        a = W'($urandom_range(0, 40));
        b = W'($urandom_range(0, 40));
      end
      do_seed(1, 0, a, 0);
      do_seed(0, 1, b, 0);
      do_start(1'($urandom_range(0, 1)));
      wait_done($sformatf("rand%0d", r));
    end

    // Reset pulse mid-run
    do_seed(1, 0, 16'd2, 0);
    do_seed(0, 1, 16'd5, 0);
    do_start(1);
    wait_index(7);
    do_reset();

    repeat (3 * T) @(posedge Clock);
    #2;
    chk("final_queue_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fib_sequencer.md
# fib_sequencer

Parametrised, self-contained recurrence sequencer for board test and demo builds. It generates a DEPTH-term integer sequence from two user seeds into an internal term file, advancing one term per prescaled tick. Two modes are supported: Fibonacci and Pell. Terms are exposed through a combinational read port and a "latest term" output that can drive the seven-segment or LED path. Overflow detection is included, with optional saturation.

## Interface
- WIDTH, 16: term width in bits (≥4).
- DEPTH, 16: number of terms stored, indices 0..DEPTH-1 (≥3).
- TICK_DIV, 30000000: Clock cycles per generated term (≥1).
- Clock  in  1  system clock; all state changes on posedge.
- Reset  in  1  asynchronous, active-low; clears all state.
- SeedA  in  1  sync, active-high: write SeedValue to term 0.
- SeedB  in  1  sync, active-high: write SeedValue to term 1.
- SeedValue  in  WIDTH  seed data, sampled when SeedA or SeedB is high.
- Start  in  1  sync, active-high pulse: begin generation from term 2.
- Mode  in  1  0 = Fibonacci, T[n]=T[n-1]+T[n-2]; 1 = Pell, T[n]=2·T[n-1]+T[n-2]. Sampled at Start.
- RdAddr  in  clog2(DEPTH)  read index.
- RdData  out  WIDTH  combinational term[RdAddr]; 0 if RdAddr ≥ DEPTH.
- Current  out  WIDTH  most recently written term (seed or generated).
- Index  out  clog2(DEPTH)+1  index of next term to write.
- Busy  out  1  high in RUN.
- Done  out  1  high in DONE.
- Overflow  out  1  sticky; set when any generated term exceeded WIDTH bits.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE. On reset, all terms, Current, Index, Busy, Done, Overflow and the tick counter are 0, and the latched mode is 0.
- Seed write (SeedA or SeedB high), any state:
  - Write the term(s).
  - Current ← SeedValue.
  - Go to IDLE; clear Done, Overflow and the tick counter; Index ← 0.
  - SeedA and SeedB both high: both terms get SeedValue.
- Start in IDLE or DONE, no seed that cycle:
  - Latch Mode, Index ← 2, clear tick counter, Overflow and Done → RUN.
- Start during RUN: ignored. Start in the same cycle as a seed: the seed wins and Start is ignored.
- RUN: the tick counter counts 0..TICK_DIV-1. At TICK_DIV-1 (the step):
  - Counter wraps to 0.
  - Compute the sum at WIDTH+2 bits from term[Index-1] and term[Index-2].
  - Write the low WIDTH bits (see Configuration) to term[Index] and to Current.
  - Index+1.
  - If any bit above WIDTH is set, Overflow ← 1.
  - If Index was DEPTH-1, go to DONE.
- DONE: terms are held. Index = DEPTH. Only a seed, Start or Reset leaves DONE.
- Recurrences always read stored (post-wrap or post-saturation) values.
- Terms 0 and 1 are never written by generation.

## Timing
- Seed: term, Current and flags update on the same posedge that samples SeedA/SeedB. Visible on RdData the next cycle.
- Start: Busy rises 1 cycle after the Start edge.
- First generated term is written TICK_DIV cycles after the Start edge.
- Term k (k≥2) is written (k-1)·TICK_DIV cycles after Start.
- Done rises and Busy falls on the same edge as the term DEPTH-1 write. Overflow updates on the same edge as the write that caused it.
- RdData has zero-cycle latency: it is a purely combinational read of the term file.
- Reset asserted mid-RUN: immediate return to the reset state; no partial write completes.

## Configuration
- FIB_SATURATE_EN defined: an overflowing term is stored as all-ones (2^WIDTH-1). Overflow is still set.
- Not defined: an overflowing term is stored modulo 2^WIDTH (wrap). Overflow is set.

## Test plan
- Fibonacci, WIDTH=16, DEPTH=16, TICK_DIV=4: SeedA=0, SeedB=1, Start, Mode=0 → term15=610, Done at 14·4 cycles after Start, Overflow=0.
- Pell, same parameters: seeds 0,1, Mode=1 → terms 2..5 = 2, 5, 12, 29; term 10 = 2378.
- Overflow, WIDTH=8, seeds 1,1, Fibonacci:
  - Without macro: term12=233, term13=121, Overflow rises at the term-13 write.
  - With FIB_SATURATE_EN: term13=255.
- Seed mid-run: pulse SeedB=7 while Index=6 → IDLE next cycle, Busy=0, Index=0, Current=7, term1=7, terms 2..5 retained.
- Start during RUN has no effect. Simultaneous SeedA+SeedB with SeedValue=3 → term0=term1=3. Then Start: term2=6, term3=9.
- Reset low for 1 cycle mid-RUN → all outputs 0, RdData=0 for every address, state IDLE.
